button_mode_ctrl: RTL and testbench

Consumes the debounced push-button level from the button debouncer, classifies each press as short or long, and maintains the filter-mode index used by the mic filter datapath. Emits single-cycle event pulses for downstream control logic. Sits directly downstream of the debouncer in the 100 MHz `clk` domain.

---
 rtl/button_pkg.sv | 15 +
 rtl/rise_detect.sv | 24 ++
 rtl/button_mode_ctrl.sv | 95 +++++++++
 tb/tb_button_mode_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared definitions for the push-button mode controller: FSM encodings and
// default timing/mode parameters for a 100 MHz system clock.
package button_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } btn_state_t;

    // 0.5 s hold at 100 MHz
    localparam int DEFAULT_LONG_CYCLES = 50_000_000;
    localparam int DEFAULT_NUM_MODES   = 4;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: registers the previous input level with a configurable
// reset value and flags cycles where the input goes from low to high.
module rise_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_prev_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_prev_reg <= RST_VAL;
        end else begin
            d_prev_reg <= d;
        end
    end

    assign rise = d & ~d_prev_reg;

endmodule

// File: rtl/button_mode_ctrl.sv
// Classifies debounced button presses as short or long, steps the filter-mode
// index on short presses and resets it on long presses.
module button_mode_ctrl
    import button_pkg::*;
#(
    parameter int LONG_CYCLES = DEFAULT_LONG_CYCLES,
    parameter int CNT_W       = 26,
    parameter int NUM_MODES   = DEFAULT_NUM_MODES,
    parameter int MODE_W      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pb_db,
    output logic [MODE_W-1:0] mode,
    output logic              short_press,
    output logic              long_press,
    output logic              held
);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LONG_CYCLES - 1);
    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);

    btn_state_t        state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [MODE_W-1:0] mode_reg;
    logic              short_reg;
    logic              long_reg;
    logic              held_reg;
    logic              press_edge;

    // Previous level resets high so a button held through reset is not a press
    rise_detect #(
        .RST_VAL (1'b1)
    ) u_rise (
        .clk  (clk),
        .rst  (rst),
        .d    (pb_db),
        .rise (press_edge)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            mode_reg  <= '0;
            short_reg <= 1'b0;
            long_reg  <= 1'b0;
            held_reg  <= 1'b0;
        end else begin
            short_reg <= 1'b0;
            long_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (press_edge) begin
                        state_reg <= ST_PRESSED;
                        cnt_reg   <= '0;
                        held_reg  <= 1'b1;
                    end
                end
                ST_PRESSED: begin
                    // Release is checked first so it wins over the threshold
                    if (!pb_db) begin
                        state_reg <= ST_IDLE;
                        short_reg <= 1'b1;
                        held_reg  <= 1'b0;
                        mode_reg  <= (mode_reg == MODE_LAST) ? '0 : mode_reg + MODE_W'(1);
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= ST_LONG;
                        long_reg  <= 1'b1;
                        mode_reg  <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_LONG: begin
                    // Counter stays frozen here, so a long hold never repeats
                    if (!pb_db) begin
                        state_reg <= ST_IDLE;
                        held_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    held_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign mode        = mode_reg;
    assign short_press = short_reg;
    assign long_press  = long_reg;
    assign held        = held_reg;

endmodule

// File: tb/tb_button_mode_ctrl.sv
// Bench for button_mode_ctrl: directed and random presses, press-duration
// reference model feeding an event scoreboard checked by a separate monitor.
module tb_button_mode_ctrl;

    localparam int L      = 8;
    localparam int NM     = 3;
    localparam int CNT_W  = 4;
    localparam int MODE_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              pb_db;
    logic [MODE_W-1:0] mode;
    logic              short_press;
    logic              long_press;
    logic              held;

    button_mode_ctrl #(
        .LONG_CYCLES (L),
        .CNT_W       (CNT_W),
        .NUM_MODES   (NM),
        .MODE_W      (MODE_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pb_db       (pb_db),
        .mode        (mode),
        .short_press (short_press),
        .long_press  (long_press),
        .held        (held)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_long;
        int mode;
        int at_edge;
    } ev_t;

    ev_t exp_q[$];

    int edge_no     = 0;
    int vectors     = 0;
    int miscompares = 0;

    // Reference model: tracks the press as a count of sampled-high cycles
    int exp_mode    = 0;
    bit exp_held    = 1'b0;
    bit m_prev      = 1'b1;
    bit m_active    = 1'b0;
    int m_high      = 0;

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %0d, required %0d", name, edge_no, act, req);
        end
    endtask

    task automatic step(input bit pb, input bit r);
        pb_db = pb;
        rst   = r;
        @(posedge clk);
        edge_no++;
        if (r) begin
            m_prev   = 1'b1;
            m_active = 1'b0;
            m_high   = 0;
            exp_mode = 0;
            exp_held = 1'b0;
        end else begin
            if (m_active) begin
                if (!pb) begin
                    if (m_high <= L) begin
                        exp_mode = (exp_mode + 1) % NM;
                        exp_q.push_back('{is_long: 1'b0, mode: exp_mode, at_edge: edge_no});
                    end
                    m_active = 1'b0;
                    exp_held = 1'b0;
                end else begin
                    m_high++;
                    if (m_high == L + 1) begin
                        exp_mode = 0;
                        exp_q.push_back('{is_long: 1'b1, mode: 0, at_edge: edge_no});
                    end
                end
            end else if (pb && !m_prev) begin
                m_active = 1'b1;
                m_high   = 1;
                exp_held = 1'b1;
            end
            m_prev = pb;
        end
        @(negedge clk);
    endtask

    task automatic press(input int hi, input int lo);
        repeat (hi) step(1'b1, 1'b0);
        repeat (lo) step(1'b0, 1'b0);
    endtask

    // Monitor: per-cycle level checks plus scoreboard pops on every pulse
    always @(negedge clk) begin
        if (edge_no > 0) begin
            chk("mode", int'(mode), exp_mode);
            chk("held", int'(held), int'(exp_held));
            while (exp_q.size() > 0 && exp_q[0].at_edge < edge_no) begin
                vectors++;
                miscompares++;
                $display("FAIL missed_pulse at edge %0d: got none, required %s at edge %0d",
                         edge_no, exp_q[0].is_long ? "long" : "short", exp_q[0].at_edge);
                void'(exp_q.pop_front());
            end
            if (short_press && long_press) begin
                chk("both_pulses", 1, 0);
            end
            if (short_press || long_press) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    $display("edge %0d: %s press, mode=%0d", edge_no,
                             long_press ? "long" : "short", mode);
                    chk("pulse_kind", int'(long_press), int'(e.is_long));
                    chk("pulse_mode", int'(mode), e.mode);
                    chk("pulse_edge", edge_no, e.at_edge);
                end
            end
        end
    end

    initial begin
        pb_db = 1'b0;
        rst   = 1'b1;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0);

        // Short press without wrap
        press(3, 3);

        // Wrap: three shorts from reset
        repeat (2) step(1'b0, 1'b1);
        repeat (3) press(2, 2);

        // Long press from mode 2
        repeat (2) press(2, 2);
        press(20, 3);

        // Threshold boundary: release at cnt = L-1, then one cycle later
        press(L, 3);
        press(L + 1, 3);

        // Button held through reset
        repeat (2) step(1'b1, 1'b0);
        repeat (2) step(1'b1, 1'b1);
        repeat (20) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        press(2, 3);

        // Reset in the middle of a press
        repeat (4) step(1'b1, 1'b0);
        repeat (2) step(1'b1, 1'b1);
        repeat (5) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);

        // Random presses with occasional resets
        repeat (80) begin
            if ($urandom_range(0, 15) == 0) begin
                step(1'($urandom_range(0, 1)), 1'b1);
            end else begin
                press(int'($urandom_range(1, 12)), int'($urandom_range(1, 4)));
            end
        end

        repeat (4) step(1'b0, 1'b0);
        chk("leftover_events", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
